// File: rtl/cmd_seq_ctrl.sv
// rtl/cmd_seq_ctrl.sv - command sequencer: fetches two-word commands from the buffer and issues them to the executor
module cmd_seq_ctrl #(
  parameter int CMD_WIDTH        = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int TRANS_ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [TRANS_ADDR_WIDTH-2:0]   start_idx,
  input  logic [TRANS_ADDR_WIDTH-1:0]   cmd_count,
  input  logic                          abort,
  input  logic                          host_wr_active,
  output logic                          cmd_rd_en,
  output logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic                          cmd_rd_valid,
  input  logic [CMD_WIDTH-1:0]          cmd_out,
  output logic                          exec_valid,
  output logic [2*CMD_WIDTH-1:0]        exec_cmd,
  input  logic                          exec_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  output logic [TRANS_ADDR_WIDTH-1:0]   issued_cnt
);

  localparam int IW = TRANS_ADDR_WIDTH - 1;
  localparam logic [TRANS_ADDR_WIDTH-1:0] CNT_ONE  = TRANS_ADDR_WIDTH'(1);
  localparam logic [TRANS_ADDR_WIDTH-1:0] MAX_CMDS = CNT_ONE << IW;
  localparam logic [IW-1:0]               IDX_ONE  = IW'(1);

  typedef enum logic [2:0] {S_IDLE, S_RD0, S_W0, S_RD1, S_W1, S_ISSUE, S_FIN} state_t;

  state_t                        state_q;
  logic [IW-1:0]                 idx_q;
  logic [TRANS_ADDR_WIDTH-1:0]   rem_q;
  logic [TRANS_ADDR_WIDTH-1:0]   issued_q;
  logic [CMD_WIDTH-1:0]          word0_q;
  logic [2*CMD_WIDTH-1:0]        exec_cmd_q;
  logic                          exec_valid_q;
  logic                          rd_en_q;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic                          busy_q;
  logic                          done_q;
  logic                          aborted_q;

  logic [TRANS_ADDR_WIDTH-1:0]   count_sat_d;
  logic [IW-1:0]                 idx_nx_d;
  logic                          eol_d;
  logic                          abort_d;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [IW-1:0] idx, input logic hi);
    return {{(ADDR_WIDTH-TRANS_ADDR_WIDTH){1'b0}}, idx, hi};
  endfunction

  assign count_sat_d = (cmd_count > MAX_CMDS) ? MAX_CMDS : cmd_count;
  assign idx_nx_d    = idx_q + IDX_ONE;
  assign eol_d       = (exec_cmd_q[CMD_WIDTH-1 -: 4] == 4'hF);
  assign abort_d     = abort && (state_q inside {S_RD0, S_W0, S_RD1, S_W1, S_ISSUE});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      rem_q        <= '0;
      issued_q     <= '0;
      word0_q      <= '0;
      exec_cmd_q   <= '0;
      exec_valid_q <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // An accept coinciding with abort still counts the command.
      if (abort_d) begin
        state_q      <= S_FIN;
        rd_en_q      <= 1'b0;
        exec_valid_q <= 1'b0;
        done_q       <= 1'b1;
        aborted_q    <= 1'b1;
        if (state_q == S_ISSUE && exec_ready) issued_q <= issued_q + CNT_ONE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              idx_q     <= start_idx;
              rem_q     <= count_sat_d;
              issued_q  <= '0;
              aborted_q <= 1'b0;
              busy_q    <= 1'b1;
              if (count_sat_d == '0) begin
                state_q <= S_FIN;
              end else begin
                state_q <= S_RD0;
                rd_en_q <= !host_wr_active;
                addr_q  <= word_addr(start_idx, 1'b0);
              end
            end
          end
          // The read strobe is registered, so a host write seen this cycle gates next cycle's strobe.
          S_RD0, S_RD1: begin
            if (rd_en_q) begin
              rd_en_q <= 1'b0;
              state_q <= (state_q == S_RD0) ? S_W0 : S_W1;
            end else if (!host_wr_active) begin
              rd_en_q <= 1'b1;
            end
          end
          S_W0: begin
            if (cmd_rd_valid) begin
              word0_q <= cmd_out;
              state_q <= S_RD1;
              rd_en_q <= !host_wr_active;
              addr_q  <= word_addr(idx_q, 1'b1);
            end
          end
          S_W1: begin
            if (cmd_rd_valid) begin
              exec_cmd_q   <= {cmd_out, word0_q};
              exec_valid_q <= 1'b1;
              state_q      <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (exec_ready) begin
              exec_valid_q <= 1'b0;
              issued_q     <= issued_q + CNT_ONE;
              idx_q        <= idx_nx_d;
              rem_q        <= rem_q - CNT_ONE;
              if (eol_d || rem_q == CNT_ONE) begin
                state_q <= S_FIN;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_RD0;
                rd_en_q <= !host_wr_active;
                addr_q  <= word_addr(idx_nx_d, 1'b0);
              end
            end
          end
          // An empty sequence reaches FIN without done set and spends one extra cycle here.
          S_FIN: begin
            if (done_q) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              done_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_rd_en  = rd_en_q;
  assign cmd_addr   = addr_q;
  assign exec_valid = exec_valid_q;
  assign exec_cmd   = exec_cmd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign issued_cnt = issued_q;

endmodule
